// File: rtl/ucie_ctl_rx_stream_buffer.sv
// RDI->FDI receive stream buffer: link-state aware FIFO between the PHY flit stream
// (no backpressure) and the adapter's valid/ready interface, with drop accounting.
module ucie_ctl_rx_stream_buffer #(
   parameter int NBYTES       = 8,
   parameter int DEPTH        = 8,
   parameter int AFULL_THRESH = DEPTH - 2,
   parameter int CNT_W        = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [3:0]                 i_state_sts,
   input  logic                       i_rdi_pl_valid,
   input  logic [NBYTES*8-1:0]        i_rdi_pl_data,
   input  logic                       i_fdi_lp_rdy,
   input  logic                       i_ovf_clear,
   output logic [NBYTES*8-1:0]        o_fdi_data,
   output logic                       o_fdi_data_valid,
   output logic [$clog2(DEPTH):0]     o_fill_level,
   output logic                       o_almost_full,
   output logic                       o_overflow_detected,
   output logic [CNT_W-1:0]           o_overflow_count,
   output logic [1:0]                 o_buf_state
);

   localparam int DW = NBYTES * 8;
   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam logic [FW-1:0] DEPTH_FILL = FW'(DEPTH);
   localparam logic [FW-1:0] AFULL_FILL = FW'(AFULL_THRESH);

   localparam logic [3:0] STS_RESET     = 4'b0000;
   localparam logic [3:0] STS_ACTIVE    = 4'b0001;
   localparam logic [3:0] STS_PMNAK     = 4'b0011;
   localparam logic [3:0] STS_L1        = 4'b0100;
   localparam logic [3:0] STS_L2        = 4'b1000;
   localparam logic [3:0] STS_LINKRESET = 4'b1001;
   localparam logic [3:0] STS_LINKERROR = 4'b1010;
   localparam logic [3:0] STS_RETRAIN   = 4'b1011;
   localparam logic [3:0] STS_DISABLED  = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_FLUSH  = 2'd3
   } buf_state_e;

   buf_state_e        state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]     fill_q, fill_d;
   logic [DW-1:0]     head_q, head_d;
   logic              ovf_flag_q, ovf_flag_d;
   logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
   logic [DW-1:0]     mem_q [DEPTH];

   logic empty, full, out_valid, pop, push, drop, flush_req, drain_req;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      head_d     = head_q;
      ovf_flag_d = ovf_flag_q;
      ovf_cnt_d  = ovf_cnt_q;

      empty     = (fill_q == '0);
      full      = (fill_q == DEPTH_FILL);
      out_valid = !empty && (state_q == ST_ACTIVE || state_q == ST_DRAIN);
      pop       = out_valid && i_fdi_lp_rdy;
      push      = i_rdi_pl_valid && (state_q == ST_ACTIVE) && (!full || pop);
      drop      = i_rdi_pl_valid && (state_q == ST_ACTIVE) && full && !pop;
      flush_req = i_state_sts inside {STS_RESET, STS_LINKRESET, STS_LINKERROR, STS_DISABLED};
      drain_req = i_state_sts inside {STS_PMNAK, STS_L1, STS_L2, STS_RETRAIN};

      case (state_q)
         ST_IDLE:   if (i_state_sts == STS_ACTIVE) state_d = ST_ACTIVE;
         ST_ACTIVE: begin
            if (flush_req)      state_d = ST_FLUSH;
            else if (drain_req) state_d = ST_DRAIN;
         end
         ST_DRAIN:  begin
            if (flush_req)                        state_d = ST_FLUSH;
            else if (i_state_sts == STS_ACTIVE)   state_d = ST_ACTIVE;
            else if (empty)                       state_d = ST_IDLE;
         end
         ST_FLUSH:  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      fill_d = fill_q + FW'(1);
      else if (pop && !push) fill_d = fill_q - FW'(1);

      // Flush discards everything, including a flit pushed or popped on the entry edge.
      if (state_d == ST_FLUSH && state_q != ST_FLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
      end

      // NOTE: the head is registered so the data output has a defined reset value; when the
      // slot being exposed is written on this same edge, the incoming flit is forwarded.
      if (fill_d != '0)
         head_d = (push && wr_ptr_q == rd_ptr_d) ? i_rdi_pl_data : mem_q[rd_ptr_d];

      if (drop) begin
         ovf_flag_d = 1'b1;
         if (i_ovf_clear)          ovf_cnt_d = CNT_W'(1);
         else if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      end else if (i_ovf_clear) begin
         ovf_flag_d = 1'b0;
         ovf_cnt_d  = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         head_q     <= '0;
         ovf_flag_q <= 1'b0;
         ovf_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         head_q     <= head_d;
         ovf_flag_q <= ovf_flag_d;
         ovf_cnt_q  <= ovf_cnt_d;
      end
   end

   // NOTE: storage has no reset; entries are only read after being written, so resetting
   // them would just cost flops.
   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q] <= i_rdi_pl_data;
   end

   assign o_fdi_data          = head_q;
   assign o_fdi_data_valid    = out_valid;
   assign o_fill_level        = fill_q;
   assign o_almost_full       = (fill_q >= AFULL_FILL);
   assign o_overflow_detected = ovf_flag_q;
   assign o_overflow_count    = ovf_cnt_q;
   assign o_buf_state         = state_q;

endmodule
